// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared widths, types and the sign-extending multiply helper
//                for the FIR tap multiplier slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int PROD_W         = 32;
    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_COEF_W = 16;

    typedef logic signed [DEFAULT_DATA_W-1:0] sample_t;
    typedef logic signed [DEFAULT_COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0]         prod_t;

    // Operands arrive already sign-extended to 32 bits; since the sum of the
    // operand widths never exceeds 32, the low 32 bits are the exact product.
    function automatic prod_t sext_mul(input prod_t a, input prod_t b);
        return a * b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_coef_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fir_coef_bank
//  Description : N-entry signed coefficient register file with a single
//                write port. Out-of-range addresses are ignored; reset
//                clears every entry to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int N      = 8,
    parameter int COEF_W = DEFAULT_COEF_W,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [COEF_W-1:0] wr_data,
    output logic signed [COEF_W-1:0] coef [0:N-1]
);

    logic signed [COEF_W-1:0] coef_q [0:N-1];
    logic signed [COEF_W-1:0] coef_d [0:N-1];
    logic                     addr_in_range;

    // Only matters for non-power-of-two N, where the address field can
    // encode indices past the last tap.
    assign addr_in_range = (int'(wr_addr) < N);

    // Next-state: hold every entry, overwrite the addressed one on a write.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            coef_d[k] = coef_q[k];
            if (wr_en && addr_in_range && (int'(wr_addr) == k)) begin
                coef_d[k] = wr_data;
            end
        end
    end

    // Coefficient storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                coef_q[k] <= coef_d[k];
            end
        end
    end

    assign coef = coef_q;

endmodule
`default_nettype wire

// File: rtl/fir_tap_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tap_multiplier
//  Description : N-deep sample delay line plus writable coefficient bank,
//                producing N registered full-precision signed products per
//                accepted sample for the downstream adder tree.
//                Build option FIR_TAP_MULT_OUT_REG_EN adds an output register
//                after the product stage (latency 3 instead of 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_tap_multiplier
    import fir_pkg::*;
#(
    parameter int N      = 8,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int COEF_W = DEFAULT_COEF_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic                     coef_wr_en,
    input  logic [$clog2(N)-1:0]     coef_wr_addr,
    input  logic signed [COEF_W-1:0] coef_wr_data,
    output logic                     out_valid,
    output logic signed [PROD_W-1:0] out_products [0:N-1],
    output logic                     primed
);

`ifdef FIR_TAP_MULT_OUT_REG_EN
    localparam int LATENCY = 3;
`else
    localparam int LATENCY = 2;
`endif
    localparam int FILL_W = $clog2(N + 1);

    logic signed [DATA_W-1:0] tap_q  [0:N-1];
    logic signed [DATA_W-1:0] tap_d  [0:N-1];
    logic signed [COEF_W-1:0] coef   [0:N-1];
    prod_t                    prod_q [0:N-1];
    prod_t                    prod_d [0:N-1];
    logic [LATENCY-1:0]       vld_q;
    logic [LATENCY-1:0]       vld_d;
    logic [FILL_W-1:0]        fill_q;
    logic [FILL_W-1:0]        fill_d;

    fir_coef_bank #(
        .N      (N),
        .COEF_W (COEF_W)
    ) u_coef_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (coef_wr_en),
        .wr_addr (coef_wr_addr),
        .wr_data (coef_wr_data),
        .coef    (coef)
    );

    // Delay line: shift one place per accepted sample, hold otherwise.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            tap_d[k] = tap_q[k];
        end
        if (in_valid) begin
            tap_d[0] = in_sample;
            for (int k = 1; k < N; k++) begin
                tap_d[k] = tap_q[k-1];
            end
        end
    end

    // Valid pipe: bit 0 marks a freshly shifted delay line, top bit is out_valid.
    always_comb begin
        vld_d = {vld_q[LATENCY-2:0], in_valid};
    end

    // Multiply stage: refresh products only when the delay line just moved.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            prod_d[k] = prod_q[k];
            if (vld_q[0]) begin
                prod_d[k] = sext_mul(PROD_W'(tap_q[k]), PROD_W'(coef[k]));
            end
        end
    end

    // Fill counter: counts accepted samples and parks at N, never wraps.
    always_comb begin
        fill_d = fill_q;
        if (in_valid && (fill_q != FILL_W'(N))) begin
            fill_d = fill_q + FILL_W'(1);
        end
    end

    // Pipeline state registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                tap_q[k]  <= '0;
                prod_q[k] <= '0;
            end
            vld_q  <= '0;
            fill_q <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                tap_q[k]  <= tap_d[k];
                prod_q[k] <= prod_d[k];
            end
            vld_q  <= vld_d;
            fill_q <= fill_d;
        end
    end

`ifdef FIR_TAP_MULT_OUT_REG_EN
    prod_t oreg_q [0:N-1];
    prod_t oreg_d [0:N-1];

    // Output register: follows the product register one cycle later.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            oreg_d[k] = oreg_q[k];
            if (vld_q[1]) begin
                oreg_d[k] = prod_q[k];
            end
        end
    end

    // Output register storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                oreg_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                oreg_q[k] <= oreg_d[k];
            end
        end
    end

    assign out_products = oreg_q;
`else
    assign out_products = prod_q;
`endif

    assign out_valid = vld_q[LATENCY-1];
    assign primed    = (fill_q == FILL_W'(N));

endmodule
`default_nettype wire
